// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer widths and Gray/binary conversion helpers for the async FIFO
package fifo_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_PTR_W  = DEF_ADDR_W + 1;
  localparam int CONV_W     = 32;

  // Callers zero-extend into CONV_W bits and truncate the result back to their own width.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = g;
    for (int i = 1; i < CONV_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// rtl/gray2bin_conv.sv - parameterised Gray-to-binary conversion as an XOR prefix from the MSB
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int W = DEF_PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/w_ptr_handler.sv
// rtl/w_ptr_handler.sv - write-domain pointer, full/almost-full/level flags and sticky overflow
module w_ptr_handler
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_MARGIN = 2
) (
  input  logic              i_wclk,
  input  logic              i_rst_n,
  input  logic              i_wen,
  input  logic [ADDR_W:0]   g_r_ptr_sync,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_wmem_en,
  output logic [ADDR_W:0]   g_w_ptr,
  output logic              full_flag,
  output logic              almost_full_flag,
  output logic [ADDR_W:0]   o_wlevel,
  output logic              overflow_err
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] w_bin;
  logic [PTR_W-1:0] w_bin_next;
  logic [PTR_W-1:0] w_gnext;
  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_match;
  logic             wr_accept;

  gray2bin_conv #(.W(PTR_W)) u_r_conv (
    .gray (g_r_ptr_sync),
    .bin  (r_bin)
  );

  assign wr_accept  = i_wen & ~full_flag;
  assign o_wmem_en  = wr_accept;
  assign o_waddr    = w_bin[ADDR_W-1:0];
  assign w_bin_next = wr_accept ? w_bin + PTR_W'(1) : w_bin;
  assign w_gnext    = wr_accept ? PTR_W'(bin2gray(CONV_W'(w_bin_next))) : g_w_ptr;

  // Full in Gray space: writer one lap ahead means the top two bits differ, the rest match.
  assign full_match = {~g_r_ptr_sync[ADDR_W:ADDR_W-1], g_r_ptr_sync[ADDR_W-2:0]};
  assign level_next = w_bin_next - r_bin;

  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_bin            <= '0;
      g_w_ptr          <= '0;
      full_flag        <= 1'b0;
      almost_full_flag <= 1'b0;
      o_wlevel         <= '0;
      overflow_err     <= 1'b0;
    end else begin
      w_bin            <= w_bin_next;
      g_w_ptr          <= w_gnext;
      full_flag        <= (w_gnext == full_match);
      almost_full_flag <= (level_next >= AF_THRESH);
      o_wlevel         <= level_next;
      overflow_err     <= overflow_err | (i_wen & full_flag);
    end
  end

endmodule

// File: tb/tb_w_ptr_handler.sv
// tb/tb_w_ptr_handler.sv - self-checking bench for w_ptr_handler against a write/read count model
module tb_w_ptr_handler;

  logic       i_wclk = 1'b0;
  logic       i_rst_n;
  logic       i_wen;
  logic [3:0] g_r_ptr_sync;
  logic [2:0] o_waddr;
  logic       o_wmem_en;
  logic [3:0] g_w_ptr;
  logic       full_flag;
  logic       almost_full_flag;
  logic [3:0] o_wlevel;
  logic       overflow_err;

  w_ptr_handler #(.ADDR_W(3), .AF_MARGIN(2)) dut (
    .i_wclk           (i_wclk),
    .i_rst_n          (i_rst_n),
    .i_wen            (i_wen),
    .g_r_ptr_sync     (g_r_ptr_sync),
    .o_waddr          (o_waddr),
    .o_wmem_en        (o_wmem_en),
    .g_w_ptr          (g_w_ptr),
    .full_flag        (full_flag),
    .almost_full_flag (almost_full_flag),
    .o_wlevel         (o_wlevel),
    .overflow_err     (overflow_err)
  );

  always #5 i_wclk = ~i_wclk;

  int total = 0;
  int bad   = 0;
  // Model: total writes accepted and total reads seen by the write domain.
  int m_w   = 0;
  int m_r   = 0;
  int m_rc  = 0;
  bit m_ovf = 1'b0;
  bit m_acc = 1'b0;

  function automatic logic [3:0] gray4(input int n);
    int x;
    x = n % 16;
    return 4'(x ^ (x >> 1));
  endfunction

  function automatic int lvl();
    return m_w - m_r;
  endfunction

  task automatic apply(input logic wen, input int rc);
    i_wen        = wen;
    g_r_ptr_sync = gray4(rc);
    m_rc         = rc;
    m_acc        = wen && (lvl() != 8);
    #1;
  endtask

  task automatic tick();
    @(posedge i_wclk);
    if (i_wen && !m_acc) m_ovf = 1'b1;
    m_w = m_w + (m_acc ? 1 : 0);
    m_r = m_rc;
    @(negedge i_wclk);
  endtask

  task automatic do_reset();
    i_rst_n      = 1'b0;
    i_wen        = 1'b0;
    g_r_ptr_sync = 4'b0000;
    m_w = 0; m_r = 0; m_rc = 0; m_ovf = 1'b0;
    repeat (2) @(negedge i_wclk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({g_w_ptr, o_waddr, full_flag, almost_full_flag, o_wlevel, overflow_err} !== 14'd0) begin
      bad++;
      $display("FAIL reset_initial got=%b want=0", {g_w_ptr, o_waddr, full_flag, almost_full_flag, o_wlevel, overflow_err});
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 0);
      tick();
    end
    total++;
    if (g_w_ptr !== 4'b0010) begin
      bad++;
      $display("FAIL reset_prewrites g_w_ptr got=%b want=0010", g_w_ptr);
    end
    @(posedge i_wclk);
    #2;
    i_rst_n = 1'b0;
    i_wen   = 1'b0;
    #1;
    total++;
    if ({g_w_ptr, o_waddr, full_flag, almost_full_flag, o_wlevel, overflow_err, o_wmem_en} !== 15'd0) begin
      bad++;
      $display("FAIL reset_async got=%b want=0", {g_w_ptr, o_waddr, full_flag, almost_full_flag, o_wlevel, overflow_err, o_wmem_en});
    end
    do_reset();
  endtask

  task automatic test_fill();
    logic [3:0] seq [8];
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 0);
      total++;
      if (o_wmem_en !== 1'b1) begin
        bad++;
        $display("FAIL fill_wmem_en write=%0d got=%b want=1", i + 1, o_wmem_en);
      end
      tick();
      total++;
      if (g_w_ptr !== seq[i] || g_w_ptr !== gray4(m_w)) begin
        bad++;
        $display("FAIL fill_gwptr write=%0d got=%b want=%b", i + 1, g_w_ptr, seq[i]);
      end
      total++;
      if (almost_full_flag !== (lvl() >= 6) || full_flag !== (lvl() == 8) || o_wlevel !== 4'(lvl())) begin
        bad++;
        $display("FAIL fill_flags write=%0d got af=%b full=%b lvl=%0d want af=%b full=%b lvl=%0d",
                 i + 1, almost_full_flag, full_flag, o_wlevel, lvl() >= 6, lvl() == 8, lvl());
      end
    end
    total++;
    if (full_flag !== 1'b1 || o_wlevel !== 4'd8) begin
      bad++;
      $display("FAIL fill_full got full=%b lvl=%0d want full=1 lvl=8", full_flag, o_wlevel);
    end
  endtask

  task automatic test_overflow();
    apply(1'b1, 0);
    total++;
    if (o_wmem_en !== 1'b0) begin
      bad++;
      $display("FAIL ovf_wmem_en got=%b want=0", o_wmem_en);
    end
    tick();
    total++;
    if (g_w_ptr !== 4'b1100 || overflow_err !== 1'b1 || o_wlevel !== 4'd8) begin
      bad++;
      $display("FAIL ovf_state got gw=%b ovf=%b lvl=%0d want gw=1100 ovf=1 lvl=8", g_w_ptr, overflow_err, o_wlevel);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 0);
      tick();
    end
    total++;
    if (overflow_err !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", overflow_err);
    end
  endtask

  task automatic test_full_release();
    apply(1'b0, 1);
    tick();
    total++;
    if (full_flag !== 1'b0 || o_wlevel !== 4'd7) begin
      bad++;
      $display("FAIL release got full=%b lvl=%0d want full=0 lvl=7", full_flag, o_wlevel);
    end
    apply(1'b1, 1);
    total++;
    if (o_wmem_en !== 1'b1 || o_waddr !== 3'b000) begin
      bad++;
      $display("FAIL release_write got en=%b addr=%b want en=1 addr=000", o_wmem_en, o_waddr);
    end
    tick();
    total++;
    if (full_flag !== 1'b1 || o_wlevel !== 4'd8) begin
      bad++;
      $display("FAIL release_refull got full=%b lvl=%0d want full=1 lvl=8", full_flag, o_wlevel);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    total++;
    if (overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_ovf_cleared got=%b want=0", overflow_err);
    end
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, (lvl() >= 4) ? m_r + 1 : m_r);
      tick();
      total++;
      if (full_flag !== (lvl() == 8) || g_w_ptr !== gray4(m_w) || o_waddr !== 3'(m_w % 8)) begin
        bad++;
        $display("FAIL wrap_step i=%0d got full=%b gw=%b addr=%b want full=%b gw=%b addr=%0d",
                 i, full_flag, g_w_ptr, o_waddr, lvl() == 8, gray4(m_w), m_w % 8);
      end
    end
    total++;
    if (g_w_ptr !== 4'b0000 || o_waddr !== 3'b000) begin
      bad++;
      $display("FAIL wrap_end got gw=%b addr=%b want gw=0000 addr=000", g_w_ptr, o_waddr);
    end
  endtask

  task automatic test_same_cycle();
    while (lvl() < 7) begin
      apply(1'b1, m_r);
      tick();
    end
    apply(1'b1, m_r + 1);
    total++;
    if (o_wmem_en !== 1'b1) begin
      bad++;
      $display("FAIL same_wmem_en got=%b want=1", o_wmem_en);
    end
    tick();
    total++;
    if (o_wlevel !== 4'd7 || full_flag !== 1'b0 || almost_full_flag !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle got lvl=%0d full=%b af=%b want lvl=7 full=0 af=1", o_wlevel, full_flag, almost_full_flag);
    end
  endtask

  task automatic test_random();
    int rc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rc = m_r;
      if (m_r < m_w && $urandom_range(0, 99) < 45) rc = m_r + 1;
      apply(logic'($urandom_range(0, 99) < 60), rc);
      total++;
      if (o_wmem_en !== m_acc) begin
        bad++;
        $display("FAIL rand_wmem_en i=%0d got=%b want=%b", i, o_wmem_en, m_acc);
      end
      tick();
      total++;
      if (g_w_ptr !== gray4(m_w) || o_waddr !== 3'(m_w % 8) || o_wlevel !== 4'(lvl()) ||
          full_flag !== (lvl() == 8) || almost_full_flag !== (lvl() >= 6) || overflow_err !== m_ovf) begin
        bad++;
        $display("FAIL rand_state i=%0d got gw=%b addr=%b lvl=%0d full=%b af=%b ovf=%b want gw=%b addr=%0d lvl=%0d full=%b af=%b ovf=%b",
                 i, g_w_ptr, o_waddr, o_wlevel, full_flag, almost_full_flag, overflow_err,
                 gray4(m_w), m_w % 8, lvl(), lvl() == 8, lvl() >= 6, m_ovf);
      end
    end
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_wen        = 1'b0;
    g_r_ptr_sync = 4'b0000;
    @(negedge i_wclk);
    test_reset();
    test_fill();
    test_overflow();
    test_full_release();
    test_wrap();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
